// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the pipelined divider and its issue controller.
//   DIV_LAT_64 : issue-to-result latency of a 64-bit divide
//   DIV_LAT_32 : issue-to-result latency of a 32-bit (W) divide
//   DIV_CNT_W  : default width of the in-flight counter
package div_issue_ctrl_pkg;

    localparam int DIV_LAT_64 = 33;
    localparam int DIV_LAT_32 = 17;
    localparam int DIV_CNT_W  = 6;

    // True when a cnt_w-bit counter can hold max_ops without wrapping.
    function automatic bit cnt_fits(input int cnt_w, input int max_ops);
        return (64'd1 << cnt_w) > 64'(max_ops);
    endfunction

endpackage

// File: rtl/div_issue_if.sv
// Request handshake between the rename/read stage and the divider issue controller.
//   req_valid : head request is a divide
//   req_op32  : head request is a W-form (32-bit) op
//   req_ready : controller accepts the head request this cycle
//   issue     : qualified divider input valid (req_valid & req_ready)
interface div_issue_if;

    logic req_valid;
    logic req_op32;
    logic req_ready;
    logic issue;

    modport master (
        output req_valid,
        output req_op32,
        input  req_ready,
        input  issue
    );

    modport slave (
        input  req_valid,
        input  req_op32,
        output req_ready,
        output issue
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// Issue controller for the 64-bit pipelined divider.
// Keeps a writeback-slot reservation vector so that short (32-bit) and long
// (64-bit) ops never complete in the same cycle, counts in-flight ops, honours
// kill/drain and flags any divider completion that was not expected.
// Ports:
//   clk_i, rstn_i    : clock, asynchronous active-low reset
//   kill_i           : flush of all in-flight divides
//   drain_i          : blocks new issue
//   req              : request handshake (slave side)
//   div_out_valid_i  : divider output valid
//   wb_expect_o      : a divider result is due this cycle
//   inflight_o       : issued, not yet completed ops
//   idle_o           : inflight_o == 0
//   mismatch_o       : sticky, completion differed from expectation
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int LAT_64 = DIV_LAT_64,
    parameter int LAT_32 = DIV_LAT_32,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             kill_i,
    input  logic             drain_i,
    div_issue_if.slave       req,
    input  logic             div_out_valid_i,
    output logic             wb_expect_o,
    output logic [CNT_W-1:0] inflight_o,
    output logic             idle_o,
    output logic             mismatch_o
);

    if (LAT_32 < 1 || LAT_32 >= LAT_64 || !cnt_fits(CNT_W, LAT_64)) begin : g_bad_params
        $error("div_issue_ctrl: need 1 <= LAT_32 < LAT_64 and 2**CNT_W > LAT_64");
    end

    // res_q[k] set: a result is due k cycles from now
    logic [LAT_64:0]  res_q;
    logic [LAT_64:0]  res_d;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic             mismatch_q;
    logic             slot_busy;
    logic             ready;
    logic             issue;

    // The slot an op would land in is checked against its own latency, so
    // only a long op issued LAT_64-LAT_32 cycles earlier can block a short op.
    assign slot_busy = req.req_op32 ? res_q[LAT_32] : res_q[LAT_64];
    assign ready     = ~kill_i & ~drain_i & ~slot_busy;
    assign issue     = req.req_valid & ready;

    always_comb begin
        res_d = {1'b0, res_q[LAT_64:1]};
        if (issue) begin
            if (req.req_op32) begin
                res_d[LAT_32-1] = 1'b1;
            end else begin
                res_d[LAT_64-1] = 1'b1;
            end
        end
    end

    // Issue and completion in the same cycle cancel out.
    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(res_q[0]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_q      <= '0;
            inflight_q <= '0;
            mismatch_q <= 1'b0;
        end else if (kill_i) begin
            // The divider is flushed on this same edge; drop all bookkeeping
            // but keep the sticky error from earlier cycles.
            res_q      <= '0;
            inflight_q <= '0;
        end else begin
            res_q      <= res_d;
            inflight_q <= inflight_d;
            if (div_out_valid_i != res_q[0]) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign req.req_ready = ready;
    assign req.issue     = issue;
    assign wb_expect_o   = res_q[0];
    assign inflight_o    = inflight_q;
    assign idle_o        = (inflight_q == '0);
    assign mismatch_o    = mismatch_q;

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue controller for the 64-bit pipelined divider. It sits between the rename/read stage and the divider. It decides each cycle whether the head divide request may enter the pipeline. It keeps a writeback-slot reservation vector so that a 32-bit op (short exit) and a 64-bit op (long exit) never complete in the same cycle, because the divider would drop one of the two results. It also counts in-flight ops, honours kill and drain, and checks the divider's actual completions against the expected ones.

## Interface
- LAT_64, default 33: cycles from issue to result valid for a 64-bit op.
- LAT_32, default 17: cycles from issue to result valid for a 32-bit (W) op.
- CNT_W, default 6: width of the in-flight counter. Must satisfy 2^CNT_W > LAT_64.
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- kill_i  in  1  flush of all in-flight divides (same signal that drives the divider's kill).
- drain_i  in  1  blocks new issue (fence/CSR serialisation).
- req_valid_i  in  1  head request is a divide (unit == UNIT_DIV).
- req_op32_i  in  1  head request is a W-form op.
- req_ready_o  out  1  request accepted this cycle.
- issue_o  out  1  qualifies the divider's input valid; equals req_valid_i & req_ready_o.
- div_out_valid_i  in  1  valid of the divider's output instruction.
- wb_expect_o  out  1  a divider result is due this cycle.
- inflight_o  out  CNT_W  number of issued, not yet completed ops.
- idle_o  out  1  inflight_o == 0.
- mismatch_o  out  1  sticky: div_out_valid_i differed from wb_expect_o.

## Operation
- Reservation vector res_q[LAT_64:0]. res_q[k] = 1 means a result is due k cycles from now. wb_expect_o = res_q[0].
- Request latency: L = LAT_32 if req_op32_i, else LAT_64.
- Ready rule: req_ready_o = ~kill_i & ~drain_i & ~res_q[L]. It is combinational on req_op32_i. That is permitted; req_valid_i must not depend on req_ready_o.
- Next-state rule: res_d[k] = res_q[k+1] | (issue_o & (k+1 == L)) for k < LAT_64. res_d[LAT_64] = 0.
- Consequence: a 64-bit op issued at cycle t blocks a 32-bit issue at t+LAT_64-LAT_32 (t+16). All other mixes are conflict-free. Back-to-back issue of same-width ops is unrestricted.
- Counter: inflight_d = inflight_q + issue_o - wb_expect_o. When both are high in the same cycle, the count is unchanged. Invariant: inflight_q == popcount(res_q).
- Kill:
  - While kill_i is high, no issue occurs.
  - On the next edge, res_q, inflight_q and the result of the mismatch comparison for that cycle are cleared. mismatch_o keeps its prior sticky value.
  - The divider is killed on the same edge, so no stale completions follow.
- Mismatch check:
  - Each cycle when kill_i is low, mismatch_q is set if div_out_valid_i != res_q[0].
  - mismatch_q is cleared only by reset.
- Drain affects only ready. Ops already in flight complete normally. idle_o tells the drain source when to release.

## Timing
- Reset values: res_q = 0, inflight_o = 0, idle_o = 1, wb_expect_o = 0, mismatch_o = 0, req_ready_o = 1 (when kill_i and drain_i are low).
- Zero-cycle accept: the request is accepted in the same cycle that req_valid_i & req_ready_o is high.
- A result for an op issued at cycle t is expected exactly at t+L, where wb_expect_o = 1.
- Maximum occupancy is LAT_64 ops (one 64-bit issue every cycle). The counter must never wrap.
- Reset asserted mid-operation clears all state immediately. It is asynchronous and needs no clock.
- Kill and a completion in the same cycle: the completion is still presented by the divider (the output is combinational from its stage register), but the controller state is zeroed regardless.
- Issue and kill are mutually exclusive by construction.

## Structure
- DIV_LAT_64 and DIV_LAT_32 go in drac_pkg. The divider and this controller share them.
- One flat module. No sub-module is needed.
  - Reservation shifter: about 34 flops.
  - Counter, mismatch flop, ready logic.
- Elaboration assertion: LAT_32 < LAT_64, and both are at least 1.

## Test plan
- Reset, then idle: req_ready_o = 1, idle_o = 1, inflight_o = 0, wb_expect_o = 0 for 50 cycles.
- 64-bit issue at cycle 0, 32-bit offered from cycle 16 onward:
  - ready = 0 at cycle 16, accepted at cycle 17.
  - wb_expect_o high at cycles 33 and 34.
  - Peak inflight_o = 2.
- 33 consecutive 64-bit issues: inflight_o reaches 33. wb_expect_o stays high for cycles 33..65. inflight_o returns to 0 at cycle 66.
- 10 ops in flight, kill_i pulsed at cycle 20: no issue that cycle, inflight_o = 0 and res_q = 0 next cycle, mismatch_o stays 0.
- drain_i high with 3 ops in flight: req_ready_o = 0 throughout. idle_o rises the cycle after the last completion. Ready returns when drain_i drops.
- Inject a div_out_valid_i pulse at a cycle where wb_expect_o = 0: mismatch_o = 1 from the next cycle and stays 1 until reset.
